// File: rtl/in_port_debouncer.sv
// Four-channel input debouncer: two-flop synchronizer, then a per-channel STABLE/COUNT filter.
// Optional macro IN_DEBOUNCE_EDGE_EN adds registered rise_pulse/fall_pulse strobes.
module in_port_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] pins_in,
`ifdef IN_DEBOUNCE_EDGE_EN
   output logic [3:0] port_out,
   output logic [3:0] rise_pulse,
   output logic [3:0] fall_pulse
`else
   output logic [3:0] port_out
`endif
);

   typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0] sync1_q;
   logic [3:0] sync2_q;
   logic [3:0] stable_vec;
   logic [3:0] stable_next_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pins_in;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_chan
         state_t           state_q, state_d;
         logic [CNT_W-1:0] count_q, count_d;
         logic             stable_q, stable_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q  <= ST_STABLE;
               count_q  <= '0;
               stable_q <= 1'b0;
            end else begin
               state_q  <= state_d;
               count_q  <= count_d;
               stable_q <= stable_d;
            end
         end

         // Entering COUNT already counts the first differing sample, so the
         // level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatch.
         always_comb begin
            state_d  = state_q;
            count_d  = count_q;
            stable_d = stable_q;
            case (state_q)
               ST_STABLE: begin
                  count_d = '0;
                  if (sync2_q[gi] != stable_q) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        stable_d = sync2_q[gi];
                     end else begin
                        state_d = ST_COUNT;
                        count_d = CNT_ONE;
                     end
                  end
               end
               ST_COUNT: begin
                  if (sync2_q[gi] == stable_q) begin
                     state_d = ST_STABLE;
                     count_d = '0;
                  end else if (count_q >= CNT_LAST) begin
                     state_d  = ST_STABLE;
                     count_d  = '0;
                     stable_d = sync2_q[gi];
                  end else begin
                     count_d = count_q + CNT_ONE;
                  end
               end
               default: begin
                  state_d = ST_STABLE;
                  count_d = '0;
               end
            endcase
         end

         always_comb begin
            stable_vec[gi]      = stable_q;
            stable_next_vec[gi] = stable_d;
         end
      end
   endgenerate

   assign port_out = stable_vec;

`ifdef IN_DEBOUNCE_EDGE_EN
   logic [3:0] rise_q;
   logic [3:0] fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= stable_next_vec & ~stable_vec;
         fall_q <= ~stable_next_vec & stable_vec;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`else
   // Without strobes the next-state vector has no consumer.
   logic unused_next;
   assign unused_next = ^stable_next_vec;
`endif

endmodule

// File: tb/tb_in_port_debouncer.sv
// Directed bench for in_port_debouncer with DEBOUNCE_CYCLES=4; strobe checks only when
// IN_DEBOUNCE_EDGE_EN is defined, port_out checks are identical in both builds.
module tb_in_port_debouncer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] pins_in = 4'b0000;
   logic [3:0] port_out;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef IN_DEBOUNCE_EDGE_EN
   in_port_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .pins_in(pins_in),
      .port_out(port_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
   );
`else
   in_port_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .pins_in(pins_in), .port_out(port_out)
   );
   assign rise_pulse = 4'b0000;
   assign fall_pulse = 4'b0000;
`endif

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] exp_out;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (port_out !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_port_out: got %b want 0000", port_out);
      end
      tick();
      tick();
      rst_n = 1'b1;
      pins_in = 4'b0000;
      exp_out = 4'b0000;
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_cmp++;
         if (port_out !== exp_out) begin
            n_bad++;
            $display("FAIL idle_port_out k=%0d: got %b want %b", k, port_out, exp_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_strobes k=%0d: got rise=%b fall=%b want 0000/0000", k, rise_pulse, fall_pulse);
         end
`endif
      end
      $display("test_reset: done, port_out=%b", port_out);
   endtask

   task automatic test_rise();
      logic [3:0] exp_out, exp_rise;
      pins_in = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_out  = (k >= 6) ? 4'b0001 : 4'b0000;
         exp_rise = (k == 6) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (port_out !== exp_out) begin
            n_bad++;
            $display("FAIL rise_port_out edge=%0d: got %b want %b", k, port_out, exp_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== exp_rise || fall_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL rise_strobe edge=%0d: got rise=%b fall=%b want %b/0000", k, rise_pulse, fall_pulse, exp_rise);
         end
`endif
      end
      $display("test_rise: done, port_out=%b", port_out);
   endtask

   task automatic test_glitch();
      pins_in = 4'b0011;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) pins_in = 4'b0001;
         tick();
         n_cmp++;
         if (port_out !== 4'b0001) begin
            n_bad++;
            $display("FAIL glitch_port_out edge=%0d: got %b want 0001", k, port_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL glitch_strobe edge=%0d: got rise=%b fall=%b want 0000/0000", k, rise_pulse, fall_pulse);
         end
`endif
      end
      $display("test_glitch: done, port_out=%b", port_out);
   endtask

   task automatic test_multi();
      logic [3:0] exp_out, exp_rise, exp_fall;
      pins_in = 4'b1111;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_out  = (k >= 6) ? 4'b1111 : 4'b0001;
         exp_rise = (k == 6) ? 4'b1110 : 4'b0000;
         n_cmp++;
         if (port_out !== exp_out) begin
            n_bad++;
            $display("FAIL multi_up_port_out edge=%0d: got %b want %b", k, port_out, exp_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== exp_rise || fall_pulse !== 4'b0000) begin
            n_bad++;
            $display("FAIL multi_up_strobe edge=%0d: got rise=%b fall=%b want %b/0000", k, rise_pulse, fall_pulse, exp_rise);
         end
`endif
      end
      pins_in = 4'b0101;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_out  = (k >= 6) ? 4'b0101 : 4'b1111;
         exp_fall = (k == 6) ? 4'b1010 : 4'b0000;
         n_cmp++;
         if (port_out !== exp_out) begin
            n_bad++;
            $display("FAIL multi_dn_port_out edge=%0d: got %b want %b", k, port_out, exp_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== 4'b0000 || fall_pulse !== exp_fall) begin
            n_bad++;
            $display("FAIL multi_dn_strobe edge=%0d: got rise=%b fall=%b want 0000/%b", k, rise_pulse, fall_pulse, exp_fall);
         end
`endif
      end
      $display("test_multi: done, port_out=%b", port_out);
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_out, exp_rise;
      pins_in = 4'b0000;
      for (int k = 1; k <= 8; k++) tick();
      n_cmp++;
      if (port_out !== 4'b0000) begin
         n_bad++;
         $display("FAIL mid_settle_port_out: got %b want 0000", port_out);
      end
      pins_in = 4'b0001;
      // After four edges the channel 0 counter holds 2.
      for (int k = 1; k <= 4; k++) tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (port_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: got out=%b rise=%b fall=%b want 0000/0000/0000", port_out, rise_pulse, fall_pulse);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_out  = (k >= 6) ? 4'b0001 : 4'b0000;
         exp_rise = (k == 6) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (port_out !== exp_out) begin
            n_bad++;
            $display("FAIL mid_release_port_out edge=%0d: got %b want %b", k, port_out, exp_out);
         end
`ifdef IN_DEBOUNCE_EDGE_EN
         n_cmp++;
         if (rise_pulse !== exp_rise) begin
            n_bad++;
            $display("FAIL mid_release_rise edge=%0d: got %b want %b", k, rise_pulse, exp_rise);
         end
`endif
      end
      $display("test_reset_mid: done, port_out=%b", port_out);
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_multi();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/in_port_debouncer.md
IN_PORT_DEBOUNCER -- requirements
Module: in_port_debouncer

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive differing synchronized samples required to accept a new level (legal range 1..65535).
REQ-002 The block SHALL have a parameter CNT_W, default 16, the width of each per-channel counter, which must hold DEBOUNCE_CYCLES-1.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port pins_in, input, 4, raw asynchronous button/switch levels, one channel per bit.
REQ-006 The block SHALL have port port_out, output, 4, debounced stable levels; this port drives in_port of the I/O port register block.
REQ-007 The block SHALL have ports rise_pulse and fall_pulse, each output, 4, one-cycle per-channel edge strobes, present only under IN_DEBOUNCE_EDGE_EN.

Function
REQ-008 Each channel SHALL pass pins_in through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-009 Each channel SHALL be independent and SHALL have its own counter, state and stable register; port_out[i] is driven directly from stable[i].
REQ-010 Each channel SHALL implement two states, STABLE and COUNT, evaluated on every rising clk edge.
REQ-011 In STABLE with sync2==stable, the channel SHALL hold, with count=0.
REQ-012 In STABLE with sync2!=stable, the channel SHALL go to COUNT, or, when DEBOUNCE_CYCLES==1, SHALL load stable<=sync2 on that edge and stay in STABLE.
REQ-013 In COUNT with sync2!=stable and count<DEBOUNCE_CYCLES-1, the channel SHALL increment count.
REQ-014 In COUNT with sync2!=stable and count==DEBOUNCE_CYCLES-1, the channel SHALL load stable<=sync2, clear count and return to STABLE.
REQ-015 In COUNT with sync2==stable (glitch), the channel SHALL clear count and return to STABLE, with stable unchanged.
REQ-016 Latency: a level held constant on pins_in SHALL appear on port_out at rising edge number DEBOUNCE_CYCLES+2, counting the first edge that samples it as edge 1.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 Simultaneous changes on several channels SHALL be debounced concurrently, with no cross-channel interaction.

Reset
REQ-019 While rst_n is 0, sync1, sync2, stable, count, state (STABLE), port_out, rise_pulse and fall_pulse SHALL all be 0, asynchronously.
REQ-020 Deassertion of rst_n mid-count SHALL restart debouncing from zero; pins held high through reset SHALL reach port_out DEBOUNCE_CYCLES+2 edges after release.

Configuration
REQ-021 With macro IN_DEBOUNCE_EDGE_EN defined, the block SHALL add rise_pulse and fall_pulse outputs.
- rise_pulse[i]=1 for exactly the one cycle following the edge on which stable[i] goes 0->1.
- fall_pulse[i]=1 for exactly the one cycle following the edge on which stable[i] goes 1->0.
- Both strobes are registered.
REQ-022 Without IN_DEBOUNCE_EDGE_EN, the ports and their logic SHALL be absent, and port_out behaviour SHALL be identical to the build with the macro.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 The bench SHALL cover: reset, then pins_in=4'b0000 for 20 cycles -> port_out=4'b0000 throughout, and no strobes.
REQ-024 The bench SHALL cover: pins_in[0] 0->1 held -> port_out=4'b0001 at edge 6, and rise_pulse=4'b0001 for one cycle (macro on).
REQ-025 The bench SHALL cover: pins_in[1] high for 3 cycles, then low -> port_out[1] stays 0, and no strobe.
REQ-026 The bench SHALL cover: pins_in=4'b1111, then 4'b0101 after port_out settles -> port_out=4'b0101 six edges later, and fall_pulse=4'b1010 for one cycle.
REQ-027 The bench SHALL cover: rst_n asserted at count=2 during a rise -> port_out=0 immediately; pins still high after release -> port_out=1 six edges after release.
REQ-028 The bench SHALL cover: a build without IN_DEBOUNCE_EDGE_EN running the REQ-023..REQ-027 stimulus -> identical port_out trace.
